regfile_dump_reader: RTL and testbench

Debug-side read initiator for the CPU's 32-entry register file. On a start request it walks an address range over one register-file read port and streams each register's address and value out on a valid/ready handshake. This lets the debug path dump architectural state without touching the datapath. It drives the read address of the combinational-read register file and consumes the returned data. It sits between the register file's spare read port and the debug transport.

---
 rtl/regfile_dump_reader.sv | 162 ++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - debug read initiator that streams a register-file address range
//
// Purpose:
//   Walks an inclusive, wrap-around index range over one combinational read
//   port of the register file. It presents each (index, value) pair on a
//   valid/ready output so the debug transport can dump architectural state.
//   The block only reads. It never drives a write port.
//
// Ports:
//   clk         system clock, rising-edge
//   rst_n       asynchronous active-low reset
//   start       dump request, sampled only while idle
//   first_addr  first register index, latched on start acceptance
//   last_addr   last register index (inclusive), latched on start acceptance
//   rd_address  read address to the register file port
//   rd_data     combinational read data returned by the register file
//   out_valid   out_addr/out_data hold a dumped word
//   out_ready   consumer accepts the word on out_valid && out_ready
//   out_addr    index of the word on out_data
//   out_data    captured register value
//   busy        high from start acceptance until the cycle after done
//   done        one-cycle pulse after the last word is accepted

module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Walk pointer and inclusive end of the latched range.
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [ADDR_WIDTH-1:0] end_q;

  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  done_q;

  // Control decodes shared by the next-state logic and the datapath.
  logic accept_start;
  logic handshake;
  logic last_word;

  assign accept_start = (state_q == IDLE) && start;
  assign handshake    = (state_q == SEND) && out_ready;
  assign last_word    = (cur_q == end_q);

  // The read port always points at the walk pointer. The pointer is loaded
  // on acceptance and advanced on each handshake. This keeps the address
  // stable for the whole ADDR cycle, so rd_data has a full cycle to settle
  // before it is captured.
  assign rd_address = cur_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          state_d = last_word ? DONE : ADDR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Range pointer. Wrap-around comes from modular ADDR_WIDTH arithmetic, so
  // a first index above the last index walks through the top entry back to
  // zero with no special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      end_q <= '0;
    end else if (accept_start) begin
      cur_q <= first_addr;
      end_q <= last_addr;
    end else if (handshake && !last_word) begin
      cur_q <= cur_q + ADDR_WIDTH'(1);
    end
  end

  // Word capture. This happens only at the ADDR->SEND edge. Backpressure in
  // SEND therefore leaves the presented word frozen, even if the datapath
  // later writes that register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr_q <= '0;
      out_data_q <= '0;
    end else if (state_q == ADDR) begin
      out_addr_q <= cur_q;
      out_data_q <= rd_data;
    end
  end

  // Status flags are registered from the next state. They match the state
  // decode cycle for cycle, but they never combinationally follow start or
  // out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= (state_d == SEND);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed self-checking bench for regfile_dump_reader

module tb_regfile_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_address (rd_address),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, index 0 hardwired to zero.
  logic [31:0] regs [32];
  assign rd_data = (rd_address == 5'd0) ? 32'd0 : regs[rd_address];

  int passed = 0;
  int total  = 0;

  // Results gathered by collect() for one dump.
  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  int done_cnt, done_cyc, first_valid_cyc, busy_after_done;
  int hold_cnt, hold_bad;
  int bp_word = -1;
  int bp_len  = 0;
  int inj_cyc = -1;
  logic [4:0] inj_first;

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    // Later changes to the range inputs must not affect the running dump.
    first_addr = ~f;
    last_addr  = ~l;
  endtask

  // Cycle index c counts cycles after the accepting edge E0 (c=0 is E0..E1).
  task automatic collect(input int budget);
    logic [4:0]  sa;
    logic [31:0] sd;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; busy_after_done = -1;
    hold_cnt = 0; hold_bad = 0;
    sa = '0; sd = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == inj_cyc) begin
        start = 1'b1; first_addr = inj_first; last_addr = inj_first;
      end else begin
        start = 1'b0;
      end
      if (out_valid && got_addr.size() == bp_word && hold_cnt < bp_len) begin
        if (hold_cnt == 0) begin
          sa = out_addr; sd = out_data;
        end else if (out_addr !== sa || out_data !== sd) begin
          hold_bad++;
        end
        hold_cnt++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after_done = int'(busy);
      if (done_cyc >= 0 && c == done_cyc + 4) break;
    end
    start = 1'b0; out_ready = 1'b1;
    bp_word = -1; bp_len = 0; inj_cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b1;
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000 + k;
    regs[0] = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rd_address !== 5'd0) $display("FAIL reset_rd_address got %0d want 0", rd_address); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_addr !== 5'd0) $display("FAIL reset_out_addr got %0d want 0", out_addr); else passed++;
    total++; if (out_data !== 32'd0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    regs[5] = 32'hDEAD_BEEF;
    start_dump(5'd5, 5'd5);
    collect(30);
    total++; if (got_addr.size() != 1) $display("FAIL single_count got %0d want 1", got_addr.size()); else passed++;
    if (got_addr.size() >= 1) begin
      total++; if (got_addr[0] !== 5'd5) $display("FAIL single_addr got %0d want 5", got_addr[0]); else passed++;
      total++; if (got_data[0] !== 32'hDEAD_BEEF) $display("FAIL single_data got %h want deadbeef", got_data[0]); else passed++;
    end
    total++; if (first_valid_cyc != 1) $display("FAIL single_latency got %0d want 1", first_valid_cyc); else passed++;
    total++; if (done_cnt != 1) $display("FAIL single_done_count got %0d want 1", done_cnt); else passed++;
    total++; if (done_cyc != 2) $display("FAIL single_done_cycle got %0d want 2", done_cyc); else passed++;
    total++; if (busy_after_done != 0) $display("FAIL single_busy_after got %0d want 0", busy_after_done); else passed++;
  endtask

  task automatic test_full_dump();
    int errs;
    for (int k = 1; k < 32; k++) regs[k] = 32'h1000 + k;
    start_dump(5'd0, 5'd31);
    collect(200);
    total++; if (got_addr.size() != 32) $display("FAIL full_count got %0d want 32", got_addr.size()); else passed++;
    errs = 0;
    for (int k = 0; k < got_addr.size() && k < 32; k++) begin
      if (got_addr[k] !== 5'(k)) errs++;
      if (got_data[k] !== ((k == 0) ? 32'd0 : 32'h1000 + k)) errs++;
    end
    total++; if (errs != 0) $display("FAIL full_words got %0d bad fields want 0", errs); else passed++;
    total++; if (done_cyc != 64) $display("FAIL full_done_cycle got %0d want 64", done_cyc); else passed++;
    total++; if (done_cnt != 1) $display("FAIL full_done_count got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_wrap();
    logic [4:0] exp [4];
    exp = '{5'd30, 5'd31, 5'd0, 5'd1};
    start_dump(5'd30, 5'd1);
    collect(40);
    total++; if (got_addr.size() != 4) $display("FAIL wrap_count got %0d want 4", got_addr.size()); else passed++;
    for (int k = 0; k < got_addr.size() && k < 4; k++) begin
      total++;
      if (got_addr[k] !== exp[k]) $display("FAIL wrap_addr%0d got %0d want %0d", k, got_addr[k], exp[k]);
      else passed++;
    end
    total++; if (done_cyc != 8) $display("FAIL wrap_done_cycle got %0d want 8", done_cyc); else passed++;
  endtask

  task automatic test_backpressure();
    int errs;
    bp_word = 2; bp_len = 5;
    start_dump(5'd10, 5'd14);
    collect(60);
    total++; if (got_addr.size() != 5) $display("FAIL bp_count got %0d want 5", got_addr.size()); else passed++;
    errs = 0;
    for (int k = 0; k < got_addr.size() && k < 5; k++) begin
      if (got_addr[k] !== 5'(10 + k)) errs++;
      if (got_data[k] !== 32'h1000 + 10 + k) errs++;
    end
    total++; if (errs != 0) $display("FAIL bp_words got %0d bad fields want 0", errs); else passed++;
    total++; if (hold_cnt != 5) $display("FAIL bp_valid_held got %0d cycles want 5", hold_cnt); else passed++;
    total++; if (hold_bad != 0) $display("FAIL bp_frozen got %0d changes want 0", hold_bad); else passed++;
    total++; if (done_cyc != 15) $display("FAIL bp_done_cycle got %0d want 15", done_cyc); else passed++;
  endtask

  task automatic test_start_while_busy();
    inj_cyc = 3; inj_first = 5'd9;
    start_dump(5'd2, 5'd4);
    collect(40);
    total++; if (got_addr.size() != 3) $display("FAIL busy_start_count got %0d want 3", got_addr.size()); else passed++;
    for (int k = 0; k < got_addr.size() && k < 3; k++) begin
      total++;
      if (got_addr[k] !== 5'(2 + k)) $display("FAIL busy_start_addr%0d got %0d want %0d", k, got_addr[k], 2 + k);
      else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL busy_start_done got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_start_in_done();
    inj_cyc = 2; inj_first = 5'd12;
    start_dump(5'd6, 5'd6);
    collect(30);
    total++; if (got_addr.size() != 1) $display("FAIL done_start_count got %0d want 1", got_addr.size()); else passed++;
    total++; if (busy_after_done != 0) $display("FAIL done_start_busy got %0d want 0", busy_after_done); else passed++;
    total++; if (done_cnt != 1) $display("FAIL done_start_done got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_reset_mid_dump();
    int seen_valid;
    int seen_done;
    start_dump(5'd10, 5'd20);
    seen_valid = 0;
    for (int c = 0; c < 10 && seen_valid == 0; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    total++; if (seen_valid != 1) $display("FAIL rstmid_valid_seen got %0d want 1", seen_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_addr !== 5'd0 || out_data !== 32'd0) $display("FAIL rstmid_out_word got %0d/%h want 0/0", out_addr, out_data); else passed++;
    total++; if (busy !== 1'b0 || rd_address !== 5'd0) $display("FAIL rstmid_busy_addr got %b/%0d want 0/0", busy, rd_address); else passed++;
    seen_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    total++; if (seen_done != 0) $display("FAIL rstmid_no_done got %0d want 0", seen_done); else passed++;
    start_dump(5'd7, 5'd8);
    collect(30);
    total++; if (got_addr.size() != 2) $display("FAIL rstmid_redump_count got %0d want 2", got_addr.size()); else passed++;
    if (got_addr.size() == 2) begin
      total++;
      if (got_addr[0] !== 5'd7 || got_addr[1] !== 5'd8 || got_data[0] !== 32'h1007 || got_data[1] !== 32'h1008)
        $display("FAIL rstmid_redump_words got %0d:%h %0d:%h want 7:1007 8:1008", got_addr[0], got_data[0], got_addr[1], got_data[1]);
      else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_start_while_busy();
    test_start_in_done();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
